// File: rtl/btb_pkg.sv
// Shared defaults and helpers for the branch target buffer.
package btb_pkg;

  localparam int BTB_PC_WIDTH = 32;
  localparam int BTB_ENTRIES  = 32;
  localparam int BTB_CTR_BITS = 2;

  function automatic int tag_bits(input int pc_width, input int entries);
    return pc_width - $clog2(entries) - 2;
  endfunction

  localparam int BTB_INDEX_BITS = $clog2(BTB_ENTRIES);
  localparam int BTB_TAG_BITS   = tag_bits(BTB_PC_WIDTH, BTB_ENTRIES);

  // Weakly-taken: MSB set, rest clear; freshly allocated entries start here.
  localparam logic [BTB_CTR_BITS-1:0] CTR_WEAK_TAKEN = BTB_CTR_BITS'(1) << (BTB_CTR_BITS - 1);

  typedef struct packed {
    logic                      valid;
    logic [BTB_TAG_BITS-1:0]   tag;
    logic [BTB_PC_WIDTH-1:0]   target;
    logic [BTB_CTR_BITS-1:0]   ctr;
  } btb_entry_t;

endpackage

// File: rtl/btb_predictor_sat_counter.sv
// Saturating up/down next-value for a branch direction counter.
module sat_counter #(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] ctr,
  input  logic                inc,
  output logic [CTR_BITS-1:0] ctr_next
);

  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  always_comb begin
    ctr_next = ctr;
    if (inc) begin
      if (ctr != CTR_MAX) ctr_next = ctr + 1'b1;
    end else begin
      if (ctr != '0) ctr_next = ctr - 1'b1;
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with per-entry valid bits and saturating direction counters.
// Combinational lookup on the fetch PC; registered update from branch resolution.
module btb_predictor
  import btb_pkg::*;
#(
  parameter int PC_WIDTH = BTB_PC_WIDTH,
  parameter int ENTRIES  = BTB_ENTRIES,
  parameter int CTR_BITS = BTB_CTR_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PC_WIDTH-1:0] current_pc,
  output logic                tag_match,
  output logic                predict_taken,
  output logic [PC_WIDTH-1:0] next_pc,
  input  logic                update_valid,
  input  logic [PC_WIDTH-1:0] source_pc,
  input  logic [PC_WIDTH-1:0] target_pc,
  input  logic                branch_taken,
  input  logic                flush
);

  localparam int INDEX_BITS = $clog2(ENTRIES);
  localparam int TAG_BITS   = tag_bits(PC_WIDTH, ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

  logic [ENTRIES-1:0]  valid_q;
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [PC_WIDTH-1:0] target_q [ENTRIES];

  logic [INDEX_BITS-1:0] lk_idx, up_idx;
  logic [TAG_BITS-1:0]   lk_tag, up_tag;
  logic                  up_hit, up_en;
  logic [CTR_BITS-1:0]   ctr_next;
  logic                  pc_lsb_unused;

  assign lk_idx = current_pc[INDEX_BITS+1:2];
  assign lk_tag = current_pc[PC_WIDTH-1:INDEX_BITS+2];
  assign up_idx = source_pc[INDEX_BITS+1:2];
  assign up_tag = source_pc[PC_WIDTH-1:INDEX_BITS+2];
  assign pc_lsb_unused = &{1'b0, source_pc[1:0]};

  // Invalid entries never match, so uninitialised tag/target cannot leak X.
  assign tag_match     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign predict_taken = tag_match && ctr_q[lk_idx][CTR_BITS-1];
  assign next_pc       = predict_taken ? target_q[lk_idx] : current_pc + PC_WIDTH'(4);

  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_en  = update_valid && !flush;

  sat_counter #(.CTR_BITS(CTR_BITS)) u_sat_counter (
    .ctr      (ctr_q[up_idx]),
    .inc      (branch_taken),
    .ctr_next (ctr_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= '0;
    end else if (flush) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= '0;
    end else if (up_en) begin
      if (up_hit) begin
        ctr_q[up_idx] <= ctr_next;
      end else if (branch_taken) begin
        valid_q[up_idx] <= 1'b1;
        ctr_q[up_idx]   <= CTR_WEAK;
      end
    end
  end

  // Tag/target carry no reset; a taken update either refreshes a hit or allocates.
  always_ff @(posedge clk) begin
    if (reset && up_en && branch_taken) begin
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= target_pc;
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Directed table-driven bench for btb_predictor (PC_WIDTH=32, ENTRIES=32, CTR_BITS=2).
module tb_btb_predictor;

  logic        clk;
  logic        reset;
  logic [31:0] current_pc;
  logic        tag_match;
  logic        predict_taken;
  logic [31:0] next_pc;
  logic        update_valid;
  logic [31:0] source_pc;
  logic [31:0] target_pc;
  logic        branch_taken;
  logic        flush;

  int errors = 0;
  int checks = 0;

  btb_predictor #(.PC_WIDTH(32), .ENTRIES(32), .CTR_BITS(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .current_pc    (current_pc),
    .tag_match     (tag_match),
    .predict_taken (predict_taken),
    .next_pc       (next_pc),
    .update_valid  (update_valid),
    .source_pc     (source_pc),
    .target_pc     (target_pc),
    .branch_taken  (branch_taken),
    .flush         (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        upd;
    logic [31:0] src;
    logic [31:0] tgt;
    logic        tk;
    logic        fl;
    logic [31:0] cur;
    logic        e_match;
    logic        e_taken;
    logic [31:0] e_next;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  task automatic check_lookup(input string name, input logic em, input logic et, input logic [31:0] en);
    check({name, ".tag_match"}, {31'b0, tag_match}, {31'b0, em});
    check({name, ".predict_taken"}, {31'b0, predict_taken}, {31'b0, et});
    check({name, ".next_pc"}, next_pc, en);
  endtask

  task automatic drive(input logic upd, input logic [31:0] src, input logic [31:0] tgt,
                       input logic tk, input logic fl, input logic [31:0] cur);
    update_valid = upd;
    source_pc    = src;
    target_pc    = tgt;
    branch_taken = tk;
    flush        = fl;
    current_pc   = cur;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Each vector: inputs applied, pre-edge lookup checked, then one clock edge.
    //             upd   src           tgt           tk    fl    cur           m     t     next
    vecs.push_back({1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0044});
    vecs.push_back({1'b1, 32'h0000_1008, 32'h0000_2000, 1'b1, 1'b0, 32'h0000_1008, 1'b0, 1'b0, 32'h0000_100C});
    vecs.push_back({1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0000_1008, 1'b1, 1'b1, 32'h0000_2000});
    vecs.push_back({1'b1, 32'h0000_1008, 32'h0,        1'b0, 1'b0, 32'h0000_1008, 1'b1, 1'b1, 32'h0000_2000});
    vecs.push_back({1'b1, 32'h0000_1008, 32'h0,        1'b0, 1'b0, 32'h0000_1008, 1'b1, 1'b0, 32'h0000_100C});
    vecs.push_back({1'b1, 32'h0000_1008, 32'h0,        1'b0, 1'b0, 32'h0000_1008, 1'b1, 1'b0, 32'h0000_100C});
    vecs.push_back({1'b1, 32'h0000_1008, 32'h0000_3000, 1'b1, 1'b0, 32'h0000_1008, 1'b1, 1'b0, 32'h0000_100C});
    vecs.push_back({1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0000_1008, 1'b1, 1'b0, 32'h0000_100C});
    vecs.push_back({1'b1, 32'h0000_1008, 32'h0000_3000, 1'b1, 1'b0, 32'h0000_1008, 1'b1, 1'b0, 32'h0000_100C});
    vecs.push_back({1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0000_1008, 1'b1, 1'b1, 32'h0000_3000});
    vecs.push_back({1'b1, 32'h0000_1008, 32'h0000_3000, 1'b1, 1'b0, 32'h0000_1008, 1'b1, 1'b1, 32'h0000_3000});
    vecs.push_back({1'b1, 32'h0000_1008, 32'h0000_3000, 1'b1, 1'b0, 32'h0000_1008, 1'b1, 1'b1, 32'h0000_3000});
    vecs.push_back({1'b1, 32'h0000_1008, 32'h0,        1'b0, 1'b0, 32'h0000_1008, 1'b1, 1'b1, 32'h0000_3000});
    // ctr saturated at 3 then decremented to 2: still taken
    vecs.push_back({1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0000_1008, 1'b1, 1'b1, 32'h0000_3000});
    vecs.push_back({1'b1, 32'h0000_5000, 32'h0000_9000, 1'b0, 1'b0, 32'h0000_5000, 1'b0, 1'b0, 32'h0000_5004});
    vecs.push_back({1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0000_5000, 1'b0, 1'b0, 32'h0000_5004});
    vecs.push_back({1'b1, 32'h0000_1088, 32'h0000_4000, 1'b1, 1'b0, 32'h0000_1088, 1'b0, 1'b0, 32'h0000_108C});
    vecs.push_back({1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0000_1008, 1'b0, 1'b0, 32'h0000_100C});
    vecs.push_back({1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0000_1088, 1'b1, 1'b1, 32'h0000_4000});
    vecs.push_back({1'b1, 32'h0000_0200, 32'h0000_6000, 1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000});
    vecs.push_back({1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0000_0200, 1'b1, 1'b1, 32'h0000_6000});
    // flush with a simultaneous taken update: update must be dropped
    vecs.push_back({1'b1, 32'h0000_7010, 32'h0000_8000, 1'b1, 1'b1, 32'h0000_1088, 1'b1, 1'b1, 32'h0000_4000});
    vecs.push_back({1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0000_1088, 1'b0, 1'b0, 32'h0000_108C});
    vecs.push_back({1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0000_0200, 1'b0, 1'b0, 32'h0000_0204});
    vecs.push_back({1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0000_7010, 1'b0, 1'b0, 32'h0000_7014});

    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0000_0040);
    #2;
    check_lookup("in_reset", 1'b0, 1'b0, 32'h0000_0044);
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #2;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].upd, vecs[i].src, vecs[i].tgt, vecs[i].tk, vecs[i].fl, vecs[i].cur);
      #1;
      check_lookup($sformatf("vec%0d", i), vecs[i].e_match, vecs[i].e_taken, vecs[i].e_next);
      @(posedge clk);
      #2;
    end

    // Allocate 0x1088 again, then pull reset low between edges.
    drive(1'b1, 32'h0000_1088, 32'h0000_4000, 1'b1, 1'b0, 32'h0000_1088);
    @(posedge clk);
    #2;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0000_1088);
    #1;
    check_lookup("realloc", 1'b1, 1'b1, 32'h0000_4000);
    reset = 1'b0;
    #1;
    check_lookup("async_reset", 1'b0, 1'b0, 32'h0000_108C);

    // Update pending across an edge while reset is held: aborted.
    drive(1'b1, 32'h0000_1008, 32'h0000_2000, 1'b1, 1'b0, 32'h0000_1008);
    @(posedge clk);
    #3;
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0000_1008);
    #1;
    check_lookup("reset_abort", 1'b0, 1'b0, 32'h0000_100C);
    @(posedge clk);
    #2;
    check_lookup("reset_abort_hold", 1'b0, 1'b0, 32'h0000_100C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
Parametrised direct-mapped branch target buffer with per-entry valid bits and saturating direction counters. It is the next-PC predictor for the fetch stage. A combinational lookup on the fetch PC produces the predicted next PC. The EX-stage branch-resolution port performs a registered update/allocate. Unlike the single-bit-per-entry tag/target table it replaces, it gates prediction by direction confidence. It also supports a pipeline flush that invalidates all entries.

Parameters:
PC_WIDTH, 32, width of all PC/target buses
ENTRIES, 32, number of BTB entries; power of two, >= 2
INDEX_BITS, $clog2(ENTRIES), index width; derived, not overridden
CTR_BITS, 2, width of the saturating direction counter; >= 1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
current_pc  input  PC_WIDTH  fetch-stage PC to look up
tag_match  output  1  valid entry with matching tag at current_pc
predict_taken  output  1  tag_match and counter MSB set
next_pc  output  PC_WIDTH  predicted next fetch PC
update_valid  input  1  a branch resolved this cycle
source_pc  input  PC_WIDTH  PC of the resolved branch
target_pc  input  PC_WIDTH  resolved target of that branch
branch_taken  input  1  resolved direction
flush  input  1  synchronous invalidate of all entries

Behaviour:
- Address split: index = pc[INDEX_BITS+1:2]; tag = pc[PC_WIDTH-1:INDEX_BITS+2]; pc[1:0] ignored.
- State per entry: valid (1b), tag, target (PC_WIDTH), ctr (CTR_BITS).
- Reset (reset==0, async): all valid=0, all ctr=0. Tag/target arrays are not reset (don't-care while invalid).
- Outputs during reset and immediately after: tag_match=0, predict_taken=0, next_pc=current_pc+4.
- Lookup is combinational, zero latency:
  - tag_match = valid[idx] && tag[idx]==cur_tag
  - predict_taken = tag_match && ctr[idx][CTR_BITS-1]
  - next_pc = predict_taken ? target[idx] : current_pc+4, with the add truncated to PC_WIDTH (wraps at top of address space)
- Update is registered at posedge clk when update_valid=1 and flush=0. Let hit = the entry at idx(source_pc) is valid with matching tag.
  - hit, taken: ctr saturating +1 (max 2^CTR_BITS-1); target <= target_pc.
  - hit, not taken: ctr saturating -1 (min 0); target unchanged.
  - miss, taken: allocate/replace — valid<=1, tag<=src_tag, target<=target_pc, ctr<=2^(CTR_BITS-1) (weakly taken).
  - miss, not taken: no state change.
- Counter width rule: increment and decrement never wrap. At 3 with taken it stays 3; at 0 with not-taken it stays 0 (CTR_BITS=2).
- Flush (flush=1 at posedge): all valid <= 0 in one cycle; ctr cleared. A flush has priority over a simultaneous update; the update is dropped.
- Same-cycle lookup and update of the same index: lookup returns pre-edge contents (no bypass). The new contents are visible from the cycle after the edge.
- update_valid=0: arrays hold.
- Asserting reset mid-update aborts the update; state is cleared immediately, no clock needed.
- No X on outputs after reset, even though tag/target are uninitialised, because valid gates the match.

Decomposition:
- Package btb_pkg:
  - default PC_WIDTH/ENTRIES/CTR_BITS
  - localparam helpers for TAG_BITS = PC_WIDTH-INDEX_BITS-2
  - CTR_WEAK_TAKEN constant
  - typedef of the entry struct {valid, tag, target, ctr}
- Sub-module sat_counter: pure combinational next-value (inc/dec, saturate), parametrised by CTR_BITS. It is instantiated once on the update path.
- Arrays live in btb_predictor; no further hierarchy.

Test Plan:
- Reset, then current_pc=0x0000_0040 -> tag_match=0, predict_taken=0, next_pc=0x0000_0044.
- Update source_pc=0x0000_1008, target_pc=0x0000_2000, taken=1. Next cycle current_pc=0x0000_1008 -> tag_match=1, predict_taken=1 (ctr=2), next_pc=0x0000_2000.
- Two not-taken updates of 0x1008 -> ctr 2->1->0. Lookup gives tag_match=1, predict_taken=0, next_pc=0x0000_100C. A third not-taken update keeps ctr=0. Three taken updates -> ctr 1,2,3, then saturates at 3.
- Alias (ENTRIES=32): allocate 0x0000_1008, then taken update for 0x0000_1088 (same index 2, different tag). Lookup 0x1008 -> tag_match=0, next_pc=0x100C. Lookup 0x1088 -> hit, predict_taken=1.
- flush=1 and update_valid=1 in the same cycle -> every previously hit PC then returns tag_match=0, and the dropped update is not allocated.
- Same-edge update plus lookup of 0x0000_1008 returns old data. Separately, reset pulled low between edges -> tag_match drops to 0 asynchronously. Also check current_pc=0xFFFF_FFFC on a miss -> next_pc=0x0000_0000.
